// File: rtl/issue_window.sv
// Out-of-order issue window: buffers renamed instructions, wakes operands
// from writeback tags and issues the oldest ready instruction per cycle.
module issue_window #(
    parameter int NR_ENTRIES    = 8,
    parameter int NR_WB_PORTS   = 4,
    parameter int TRANS_ID_BITS = 3,
    parameter int NR_FU         = 5,
    parameter int PAYLOAD_W     = 128
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic                                 enq_valid_i,
    output logic                                 enq_ready_o,
    input  logic [TRANS_ID_BITS-1:0]             enq_trans_id_i,
    input  logic [$clog2(NR_FU)-1:0]             enq_fu_i,
    input  logic                                 enq_rs1_pend_i,
    input  logic                                 enq_rs2_pend_i,
    input  logic [TRANS_ID_BITS-1:0]             enq_rs1_tag_i,
    input  logic [TRANS_ID_BITS-1:0]             enq_rs2_tag_i,
    input  logic [PAYLOAD_W-1:0]                 enq_payload_i,
    input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_tag_i,
    input  logic [NR_FU-1:0]                     fu_ready_i,
    output logic                                 iss_valid_o,
    output logic [$clog2(NR_FU)-1:0]             iss_fu_o,
    output logic [TRANS_ID_BITS-1:0]             iss_trans_id_o,
    output logic [PAYLOAD_W-1:0]                 iss_payload_o,
    output logic [$clog2(NR_ENTRIES+1)-1:0]      occupancy_o
);
    localparam int FU_W  = $clog2(NR_FU);
    localparam int IDX_W = $clog2(NR_ENTRIES);
    localparam int OCC_W = $clog2(NR_ENTRIES+1);
    localparam int T     = TRANS_ID_BITS;

    logic [NR_ENTRIES-1:0] valid_q, valid_d;
    logic [NR_ENTRIES-1:0] rs1p_q, rs1p_d;
    logic [NR_ENTRIES-1:0] rs2p_q, rs2p_d;
    logic [NR_ENTRIES-1:0] age_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] age_d [NR_ENTRIES];
    logic [FU_W-1:0]       fu_q  [NR_ENTRIES];
    logic [T-1:0]          tid_q [NR_ENTRIES];
    logic [T-1:0]          rs1t_q[NR_ENTRIES];
    logic [T-1:0]          rs2t_q[NR_ENTRIES];
    logic [PAYLOAD_W-1:0]  pay_q [NR_ENTRIES];
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic [2**FU_W-1:0]    fu_rdy_ext;
    logic [NR_ENTRIES-1:0] elig, sel;
    logic [IDX_W-1:0]      free_idx;
    logic                  free_found;
    logic                  enq_fire, iss_fire;

    function automatic logic wb_hit(input logic [T-1:0] tag,
                                    input logic [NR_WB_PORTS-1:0] v,
                                    input logic [NR_WB_PORTS*T-1:0] tags);
        wb_hit = 1'b0;
        for (int p = 0; p < NR_WB_PORTS; p++)
            if (v[p] && tags[p*T +: T] == tag) wb_hit = 1'b1;
    endfunction

    assign occupancy_o = occ_q;
    assign enq_ready_o = occ_q < OCC_W'(NR_ENTRIES);
    assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
    assign iss_fire    = iss_valid_o;

    // Eligibility and oldest-first selection; out-of-range FU never ready
    always_comb begin
        fu_rdy_ext = '0;
        fu_rdy_ext[NR_FU-1:0] = fu_ready_i;
        for (int i = 0; i < NR_ENTRIES; i++)
            elig[i] = valid_q[i] && !rs1p_q[i] && !rs2p_q[i]
                      && fu_rdy_ext[fu_q[i]];
        for (int i = 0; i < NR_ENTRIES; i++) begin
            sel[i] = elig[i];
            for (int j = 0; j < NR_ENTRIES; j++)
                if (j != i && elig[j] && age_q[j][i]) sel[i] = 1'b0;
        end
        iss_valid_o    = |elig;
        iss_fu_o       = '0;
        iss_trans_id_o = '0;
        iss_payload_o  = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (sel[i]) begin
                iss_fu_o       = iss_fu_o | fu_q[i];
                iss_trans_id_o = iss_trans_id_o | tid_q[i];
                iss_payload_o  = iss_payload_o | pay_q[i];
            end
        end
    end

    // Lowest-index free slot for the next allocation
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Next state: issue, wakeup, allocation with age update, flush
    always_comb begin
        valid_d = valid_q & ~sel;
        rs1p_d  = rs1p_q;
        rs2p_d  = rs2p_q;
        age_d   = age_q;
        occ_d   = occ_q;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (valid_q[i] && wb_hit(rs1t_q[i], wb_valid_i, wb_tag_i))
                rs1p_d[i] = 1'b0;
            if (valid_q[i] && wb_hit(rs2t_q[i], wb_valid_i, wb_tag_i))
                rs2p_d[i] = 1'b0;
        end
        if (enq_fire) begin
            valid_d[free_idx] = 1'b1;
            rs1p_d[free_idx]  = enq_rs1_pend_i
                && !wb_hit(enq_rs1_tag_i, wb_valid_i, wb_tag_i);
            rs2p_d[free_idx]  = enq_rs2_pend_i
                && !wb_hit(enq_rs2_tag_i, wb_valid_i, wb_tag_i);
            age_d[free_idx]   = '0;
            for (int j = 0; j < NR_ENTRIES; j++)
                age_d[j][free_idx] = valid_q[j];
        end
        if (enq_fire && !iss_fire)
            occ_d = occ_q + OCC_W'(1);
        else if (!enq_fire && iss_fire)
            occ_d = occ_q - OCC_W'(1);
        if (flush_i) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    // State registers; entry fields are written only on allocation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            rs1p_q  <= '0;
            rs2p_q  <= '0;
            occ_q   <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                age_q[i]  <= '0;
                fu_q[i]   <= '0;
                tid_q[i]  <= '0;
                rs1t_q[i] <= '0;
                rs2t_q[i] <= '0;
                pay_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rs1p_q  <= rs1p_d;
            rs2p_q  <= rs2p_d;
            occ_q   <= occ_d;
            age_q   <= age_d;
            if (enq_fire) begin
                fu_q[free_idx]   <= enq_fu_i;
                tid_q[free_idx]  <= enq_trans_id_i;
                rs1t_q[free_idx] <= enq_rs1_tag_i;
                rs2t_q[free_idx] <= enq_rs2_tag_i;
                pay_q[free_idx]  <= enq_payload_i;
            end
        end
    end

`ifndef SYNTHESIS
    a_fu_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (enq_valid_i && enq_ready_o) |-> (int'(enq_fu_i) < NR_FU));
`endif

endmodule

// File: tb/tb_issue_window.sv
// Directed vector bench for issue_window: table of per-cycle inputs and
// expected outputs, plus a hand-written asynchronous reset sequence.
module tb_issue_window;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         enq_valid;
    logic         enq_ready;
    logic [2:0]   enq_tid;
    logic [2:0]   enq_fu;
    logic         rs1p, rs2p;
    logic [2:0]   rs1t, rs2t;
    logic [127:0] enq_pay;
    logic [3:0]   wb_valid;
    logic [11:0]  wb_tag;
    logic [4:0]   fu_ready;
    logic         iss_valid;
    logic [2:0]   iss_fu;
    logic [2:0]   iss_tid;
    logic [127:0] iss_pay;
    logic [3:0]   occ;

    int n_vec = 0;
    int n_err = 0;

    issue_window dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .enq_valid_i    (enq_valid),
        .enq_ready_o    (enq_ready),
        .enq_trans_id_i (enq_tid),
        .enq_fu_i       (enq_fu),
        .enq_rs1_pend_i (rs1p),
        .enq_rs2_pend_i (rs2p),
        .enq_rs1_tag_i  (rs1t),
        .enq_rs2_tag_i  (rs2t),
        .enq_payload_i  (enq_pay),
        .wb_valid_i     (wb_valid),
        .wb_tag_i       (wb_tag),
        .fu_ready_i     (fu_ready),
        .iss_valid_o    (iss_valid),
        .iss_fu_o       (iss_fu),
        .iss_trans_id_o (iss_tid),
        .iss_payload_o  (iss_pay),
        .occupancy_o    (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ev;
        logic [2:0] fu;
        logic [2:0] tid;
        logic       p1;
        logic [2:0] t1;
        logic       p2;
        logic [2:0] t2;
        logic [3:0] wbv;
        logic [11:0] wbt;
        logic [4:0] fr;
        logic       fl;
        logic       xv;
        logic [2:0] xtid;
        logic [2:0] xfu;
        logic [3:0] xocc;
        logic       xrdy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] pay(input logic [2:0] t);
        return {16{5'b10101, t}};
    endfunction

    function automatic void add(
        input logic ev, input logic [2:0] fu, input logic [2:0] tid,
        input logic p1, input logic [2:0] t1,
        input logic p2, input logic [2:0] t2,
        input logic [3:0] wbv, input logic [11:0] wbt,
        input logic [4:0] fr, input logic fl,
        input logic xv, input logic [2:0] xtid, input logic [2:0] xfu,
        input logic [3:0] xocc, input logic xrdy);
        vec_t v;
        v.ev = ev; v.fu = fu; v.tid = tid;
        v.p1 = p1; v.t1 = t1; v.p2 = p2; v.t2 = t2;
        v.wbv = wbv; v.wbt = wbt; v.fr = fr; v.fl = fl;
        v.xv = xv; v.xtid = xtid; v.xfu = xfu;
        v.xocc = xocc; v.xrdy = xrdy;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; enq_valid = 0; enq_tid = 0; enq_fu = 0;
        rs1p = 0; rs2p = 0; rs1t = 0; rs2t = 0; enq_pay = '0;
        wb_valid = 0; wb_tag = 0; fu_ready = 5'h1F;
    endtask

    initial begin
        // scenario 1: enqueue ready entry, issue next cycle
        add(1,0,1, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,1,0,1,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);
        // scenario 2: pending A, ready B overtakes; wakeup no bypass
        add(1,0,2, 1,5,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);
        add(1,0,3, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,1,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,3,0,2,1);
        add(0,0,0, 0,0,0,0, 4'h4,12'h140, 5'h1F,0, 0,0,0,1,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,2,0,1,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);
        // scenario 3: enqueue bypass on rs1 and rs2
        add(1,3,4, 1,3,0,0, 4'h1,12'h003, 5'h1F,0, 0,0,0,0,1);
        add(1,4,5, 0,0,1,2, 4'h8,12'h400, 5'h1F,0, 1,4,3,1,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,5,4,1,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);
        // scenario 4: fill window with pending entries
        for (int k = 0; k < 8; k++)
            add(1,0,3'(k), 1,3'(k),0,0, 0,0, 5'h1F,0, 0,0,0,4'(k),1);
        add(1,0,7, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,8,0);
        add(1,0,6, 0,0,0,0, 4'h2,12'h028, 5'h1F,0, 0,0,0,8,0);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,5,0,8,0);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,7,1);
        add(1,0,1, 0,0,0,0, 0,0,     5'h1F,1, 0,0,0,7,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);
        // scenario 5: blocked FU class, younger other class issues
        add(1,1,1, 0,0,0,0, 0,0,     5'h1D,0, 0,0,0,0,1);
        add(1,1,2, 0,0,0,0, 0,0,     5'h1D,0, 0,0,0,1,1);
        add(1,1,3, 0,0,0,0, 0,0,     5'h1D,0, 0,0,0,2,1);
        add(1,2,4, 0,0,0,0, 0,0,     5'h1D,0, 0,0,0,3,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1D,0, 1,4,2,4,1);
        add(1,0,5, 0,0,0,0, 0,0,     5'h1F,0, 1,1,1,3,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,2,1,3,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,3,1,2,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 1,5,0,1,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);
        // scenario 6: flush with simultaneous enqueue
        for (int k = 1; k <= 5; k++)
            add(1,0,3'(k), 1,7,0,0, 0,0, 5'h1F,0, 0,0,0,4'(k-1),1);
        add(1,0,6, 0,0,0,0, 0,0,     5'h1F,1, 0,0,0,5,1);
        add(0,0,0, 0,0,0,0, 4'h8,12'hE00, 5'h1F,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0, 0,0,     5'h1F,0, 0,0,0,0,1);

        idle_inputs();
        rst_n = 0;
        #12;
        n_vec++;
        chk("reset occ", occ, 0);
        chk("reset rdy", enq_ready, 1);
        chk("reset iss_valid", iss_valid, 0);
        chk("reset iss_tid", iss_tid, 0);
        chk("reset iss_fu", iss_fu, 0);
        chk("reset iss_pay", iss_pay, 0);
        rst_n = 1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            enq_valid = vecs[i].ev;
            enq_fu    = vecs[i].fu;
            enq_tid   = vecs[i].tid;
            enq_pay   = pay(vecs[i].tid);
            rs1p      = vecs[i].p1;
            rs1t      = vecs[i].t1;
            rs2p      = vecs[i].p2;
            rs2t      = vecs[i].t2;
            wb_valid  = vecs[i].wbv;
            wb_tag    = vecs[i].wbt;
            fu_ready  = vecs[i].fr;
            flush     = vecs[i].fl;
            #1;
            n_vec++;
            chk($sformatf("v%0d iss_valid", i), iss_valid, vecs[i].xv);
            chk($sformatf("v%0d iss_tid", i), iss_tid, vecs[i].xtid);
            chk($sformatf("v%0d iss_fu", i), iss_fu, vecs[i].xfu);
            chk($sformatf("v%0d iss_pay", i), iss_pay,
                vecs[i].xv ? pay(vecs[i].xtid) : 128'd0);
            chk($sformatf("v%0d occ", i), occ, vecs[i].xocc);
            chk($sformatf("v%0d rdy", i), enq_ready, vecs[i].xrdy);
            @(posedge clk); #1;
        end

        // asynchronous reset pulse with a live entry
        idle_inputs();
        enq_valid = 1; enq_tid = 6; enq_pay = pay(3'd6);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_vec++;
        chk("pre-rst iss_valid", iss_valid, 1);
        chk("pre-rst iss_tid", iss_tid, 6);
        chk("pre-rst occ", occ, 1);
        #1 rst_n = 0;
        #1;
        n_vec++;
        chk("async rst occ", occ, 0);
        chk("async rst rdy", enq_ready, 1);
        chk("async rst iss_valid", iss_valid, 0);
        chk("async rst iss_tid", iss_tid, 0);
        chk("async rst iss_pay", iss_pay, 0);
        #1 rst_n = 1;
        @(posedge clk); #1;
        n_vec++;
        chk("post-rst iss_valid", iss_valid, 0);
        chk("post-rst occ", occ, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
